// File: rtl/rr_mux4_if.sv
// Bundle of request/data/grant signals between four requesters and the
// round-robin mux arbiter. The requester side (master) drives req and din.
// The arbiter side (slave) returns grant, select, valid, the muxed bit and
// the timeout pulse.
interface rr_mux4_if;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       dout;
    logic       timeout;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  valid,
        input  dout,
        input  timeout
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output valid,
        output dout,
        output timeout
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that shares one 4:1 bit mux between four requesters.
// The owner keeps the grant until it drops req. Ownership then passes
// back-to-back to the next requester, searching from owner+1.
// Optional macro ARB_TIMEOUT_EN adds a hold counter. It force-releases an
// owner after MAX_HOLD cycles if someone else is waiting, and pulses timeout.
module rr_mux4_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    rr_mux4_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Reject an illegal hold limit at elaboration time.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_mux4_arbiter: MAX_HOLD must be in 2..255");
    end

    // First set bit of r in the order start, start+1, start+2, start+3 (mod 4).
    // The loop runs from the farthest offset down, so the nearest hit is the
    // one left in p.
    function automatic pick_t pick_first(input logic [3:0] r, input logic [1:0] start);
        pick_t      p;
        logic [1:0] idx;
        p = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic       valid_q, valid_d;
    logic [1:0] ptr_q,   ptr_d;

    logic       launch;
    logic [1:0] launch_idx;
    logic [3:0] others;
    pick_t      p;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q,  timeout_d;
`endif

    // Next-state logic: pick a new owner from IDLE, or hold, release or hand over in GRANT.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through this block leaves a latch.
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        launch     = 1'b0;
        launch_idx = sel_q;
        others     = bus.req & ~(4'b0001 << sel_q);
        p          = '0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                p = pick_first(bus.req, ptr_q);
                if (p.found) begin
                    launch     = 1'b1;
                    launch_idx = p.idx;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    // Owner released: rotate priority past it and hand over at this same edge.
                    ptr_d = sel_q + 2'd1;
                    p     = pick_first(others, sel_q + 2'd1);
                    if (p.found) begin
                        launch     = 1'b1;
                        launch_idx = p.idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_q == HOLD_LAST && |others) begin
                    // Owner has held too long while others wait: force a release.
                    ptr_d      = sel_q + 2'd1;
                    p          = pick_first(others, sel_q + 2'd1);
                    launch     = 1'b1;
                    launch_idx = p.idx;
                    timeout_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`endif
            end
        endcase

        if (launch) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << launch_idx;
            sel_d   = launch_idx;
            valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and one-cycle timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    // The shared bit is not registered. It follows the owner's lane directly.
    assign bus.dout  = valid_q ? bus.din[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter. Each check compares the packed vector
// {gnt, sel, valid, dout, timeout} against a hand-computed value. A mask drops
// sel while the arbiter is idle.
module tb_rr_mux4_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_mux4_if bus ();

    rr_mux4_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Layout: gnt[8:5] sel[4:3] valid[2] dout[1] timeout[0]
    logic [8:0] obs;
    assign obs = {bus.gnt, bus.sel, bus.valid, bus.dout, bus.timeout};

    localparam logic [8:0] M_ALL   = 9'b1111_11_111;
    localparam logic [8:0] M_NOSEL = 9'b1111_00_111;

    function automatic logic [8:0] ev(input logic [3:0] g, input logic [1:0] s,
                                      input logic v, input logic d, input logic t);
        return {g, s, v, d, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.req = '0;
        bus.din = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        bus.req = '0;
        bus.din = '0;
        #2;
        e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL reset_initial: got %b want %b", obs, e); end
        total++;
        // Requests while reset is held must not produce a grant.
        bus.req = 4'b1111;
        bus.din = 4'b1111;
        step();
        if (obs !== e) begin bad++; $display("FAIL reset_held: got %b want %b", obs, e); end
        total++;
        apply_reset();
    endtask

    task automatic test_basic();
        logic [8:0] e;
        apply_reset();
        bus.req = 4'b0001;
        bus.din = 4'b0001;
        step();
        e = ev(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL basic_grant: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0000;
        step();
        e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        if ((obs & M_NOSEL) !== e) begin bad++; $display("FAIL basic_idle: got %b want %b", obs & M_NOSEL, e); end
        total++;
    endtask

    task automatic test_rotation();
        logic [3:0] din_v;
        logic [8:0] e;
        din_v = 4'b1010;
        apply_reset();
        bus.din = din_v;
        bus.req = 4'b1111;
        step();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                e = ev(4'(1 << k), 2'(k), 1'b1, din_v[k], 1'b0);
                if (obs !== e) begin
                    bad++;
                    $display("FAIL rotation owner=%0d cyc=%0d: got %b want %b", k, c, obs, e);
                end
                total++;
                if (c == 2) bus.req[k] = 1'b0;
                step();
            end
        end
        e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        if ((obs & M_NOSEL) !== e) begin bad++; $display("FAIL rotation_idle: got %b want %b", obs & M_NOSEL, e); end
        total++;
    endtask

    task automatic test_wrap();
        logic [8:0] e;
        apply_reset();
        bus.din = 4'b0101;
        bus.req = 4'b1000;
        step();
        e = ev(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL wrap_owner3: got %b want %b", obs, e); end
        total++;
        // Waiting requesters must not pre-empt owner 3.
        bus.req = 4'b1101;
        step();
        if (obs !== e) begin bad++; $display("FAIL wrap_no_preempt: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0101;
        step();
        e = ev(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL wrap_to_0: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0100;
        step();
        e = ev(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL wrap_next_2: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        apply_reset();
        bus.req = 4'b0010;
        bus.din = 4'b0100;
        step();
        bus.req = 4'b0110;
        step();
        e = ev(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL b2b_owner1: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0100;
        step();
        e = ev(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL b2b_handover: got %b want %b", obs, e); end
        total++;
        // dout follows din with no clock edge.
        bus.din = 4'b0000;
        #1;
        e = ev(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL b2b_dout_comb: got %b want %b", obs, e); end
        total++;
        // Owner 2 drops while 3 and 0 rise at the same edge: search from 3 wins.
        bus.din = 4'b1000;
        bus.req = 4'b1001;
        step();
        e = ev(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL b2b_simultaneous: got %b want %b", obs, e); end
        total++;
        // Requester 0 withdraws before being served: it is never granted.
        bus.req = 4'b1000;
        step();
        bus.req = 4'b0000;
        step();
        e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        if ((obs & M_NOSEL) !== e) begin bad++; $display("FAIL b2b_withdrawn: got %b want %b", obs & M_NOSEL, e); end
        total++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        apply_reset();
        // Move ptr away from 0 first, so the post-reset search from 0 is observable.
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0100;
        step();
        e = ev(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL rstmid_owner2: got %b want %b", obs, e); end
        total++;
        #2;
        rst_n = 1'b0;
        #1;
        e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL rstmid_async: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b1010;
        bus.din = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        e = ev(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL rstmid_search0: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0000;
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [8:0] e;
        apply_reset();
        bus.din = 4'b0000;
        bus.req = 4'b0011;
        step();
        for (int c = 0; c < 4; c++) begin
            e = ev(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
            if (obs !== e) begin bad++; $display("FAIL timeout_hold0 cyc=%0d: got %b want %b", c, obs, e); end
            total++;
            step();
        end
        e = ev(4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        if (obs !== e) begin bad++; $display("FAIL timeout_force1: got %b want %b", obs, e); end
        total++;
        step();
        e = ev(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL timeout_pulse_end: got %b want %b", obs, e); end
        total++;
        step();
        step();
        step();
        // The force-released owner 0 is still requesting and comes back.
        e = ev(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        if (obs !== e) begin bad++; $display("FAIL timeout_force0: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_timeout_alone();
        logic [8:0] e;
        apply_reset();
        bus.din = 4'b0001;
        bus.req = 4'b0001;
        step();
        for (int c = 0; c < 8; c++) begin
            e = ev(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
            if (obs !== e) begin bad++; $display("FAIL alone_keep cyc=%0d: got %b want %b", c, obs, e); end
            total++;
            step();
        end
        // The counter has saturated, so a newcomer triggers a release at the next edge.
        bus.req = 4'b0011;
        step();
        e = ev(4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        if (obs !== e) begin bad++; $display("FAIL alone_saturated_force: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0000;
        step();
    endtask
`else
    task automatic test_no_timeout();
        logic [8:0] e;
        apply_reset();
        bus.din = 4'b0010;
        bus.req = 4'b0011;
        step();
        for (int c = 0; c < 20; c++) begin
            e = ev(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
            if (obs !== e) begin bad++; $display("FAIL notimeout_hold cyc=%0d: got %b want %b", c, obs, e); end
            total++;
            step();
        end
        bus.req = 4'b0010;
        step();
        e = ev(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        if (obs !== e) begin bad++; $display("FAIL notimeout_release: got %b want %b", obs, e); end
        total++;
        bus.req = 4'b0000;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_alone();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
